multicycle_control: RTL and testbench

//  Multi-cycle RV32I control FSM; successor to the single-cycle combinational decoder.

---
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, latches the IR, traps on bad opcodes.
// Optional feature: define PERF_CNT_EN to add the instret retirement counter and its CNT_W parameter.
module multicycle_control #(
  parameter int unsigned ALU_W       = 4,
  parameter int unsigned MEM_TIMEOUT = 16
`ifdef PERF_CNT_EN
  ,
  parameter int unsigned CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             register_write_en,
  output logic [ALU_W-1:0] alu_control_en,
  output logic             alu_src_imm,
  output logic [1:0]       wb_sel,
  output logic             pc_write_en,
  output logic [1:0]       pc_src,
  output logic             illegal_instr,
  output logic             mem_fault
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  localparam int unsigned TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             known_op;
  logic             r_ok;
  logic             mem_expired;
  logic             set_illegal;
  logic             set_fault;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  // Only ADD/SUB and SRL/SRA have an IR[30] variant among R-type ops.
  assign r_ok   = !instr[30] || (funct3 == 3'b000) || (funct3 == 3'b101);
  assign mem_expired = (MEM_TIMEOUT != 0) && (timer == TMR_W'(MEM_TIMEOUT - 1));

  always_comb begin : opcode_check
    known_op = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: known_op = 1'b1;
      default: known_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin : ir_timer_flags
    if (!rst_n) begin
      instr         <= '0;
      timer         <= '0;
      illegal_instr <= 1'b0;
      mem_fault     <= 1'b0;
    end else begin
      if (state == S_FETCH && imem_rvalid) instr <= imem_rdata;
      timer <= (state == S_MEM) ? timer + TMR_W'(1) : '0;
      if (set_illegal) illegal_instr <= 1'b1;
      if (set_fault)   mem_fault     <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin : perf_cnt
    if (!rst_n)           instret <= '0;
    else if (pc_write_en) instret <= instret + CNT_W'(1);
  end
`endif

  always_comb begin : fsm_comb
    state_nxt         = state;
    imem_req          = 1'b0;
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    register_write_en = 1'b0;
    alu_control_en    = '0;
    alu_src_imm       = 1'b0;
    wb_sel            = 2'b00;
    pc_write_en       = 1'b0;
    pc_src            = 2'b00;
    set_illegal       = 1'b0;
    set_fault         = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (known_op) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt   = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_imm = (opcode != OP_R) && (opcode != OP_BRANCH);
        state_nxt   = S_WB;
        case (opcode)
          OP_R: begin
            if (r_ok) begin
              alu_control_en = ALU_W'({instr[30], funct3});
            end else begin
              state_nxt   = S_TRAP;
              set_illegal = 1'b1;
            end
          end
          OP_I: alu_control_en = ALU_W'({(funct3 == 3'b101) && instr[30], funct3});
          OP_LOAD, OP_STORE: begin
            alu_control_en = ALU_W'(ALU_ADD);
            state_nxt      = S_MEM;
          end
          OP_BRANCH: begin
            alu_control_en = ALU_W'(ALU_SUB);
            pc_write_en    = 1'b1;
            pc_src         = branch_taken ? 2'b01 : 2'b00;
            state_nxt      = S_FETCH;
          end
          default: alu_control_en = ALU_W'(ALU_ADD);
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_write_en = 1'b1;
            state_nxt   = S_FETCH;
          end else begin
            state_nxt   = S_WB;
          end
        end else if (mem_expired) begin
          state_nxt = S_TRAP;
          set_fault = 1'b1;
        end
      end
      S_WB: begin
        register_write_en = (instr[11:7] != 5'd0);
        pc_write_en       = 1'b1;
        state_nxt         = S_FETCH;
        case (opcode)
          OP_JAL:  begin pc_src = 2'b01; wb_sel = 2'b10; end
          OP_JALR: begin pc_src = 2'b10; wb_sel = 2'b10; end
          OP_LUI:  wb_sel = 2'b11;
          OP_LOAD: wb_sel = 2'b01;
          default: wb_sel = 2'b00;
        endcase
      end
      S_TRAP: state_nxt = S_TRAP;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction scoreboard of expected retirement behaviour.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_rdata, instr;
  logic        dmem_req, dmem_we, dmem_ready, branch_taken;
  logic        register_write_en, alu_src_imm, pc_write_en;
  logic [3:0]  alu_control_en;
  logic [1:0]  wb_sel, pc_src;
  logic        illegal_instr, mem_fault;
`ifdef PERF_CNT_EN
  logic [31:0] instret;
`endif

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken),
    .register_write_en(register_write_en), .alu_control_en(alu_control_en),
    .alu_src_imm(alu_src_imm), .wb_sel(wb_sel),
    .pc_write_en(pc_write_en), .pc_src(pc_src),
    .illegal_instr(illegal_instr), .mem_fault(mem_fault)
`ifdef PERF_CNT_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  retire_c;
    logic [1:0]  pc_src;
    logic [7:0]  wr_n;
    logic [1:0]  wb_sel;
    logic [3:0]  alu;
    logic        imm;
    logic [7:0]  mem_n;
    logic        we;
    logic [7:0]  imem_n;
    logic [31:0] ir;
    logic        ill;
    logic        flt;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ret_since_reset = 0;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW    = 32'h0000A183;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_BEQ   = 32'h00208463;

  function automatic obs_t mk_exp(input int rc, input logic [1:0] ps, input int wr,
                                  input logic [1:0] wb, input logic [3:0] alu, input logic imm,
                                  input int mem, input logic we, input int imem,
                                  input logic [31:0] ir, input logic ill, input logic flt);
    obs_t e;
    e.retire_c = 8'(rc); e.pc_src = ps; e.wr_n = 8'(wr); e.wb_sel = wb;
    e.alu = alu; e.imm = imm; e.mem_n = 8'(mem); e.we = we; e.imem_n = 8'(imem);
    e.ir = ir; e.ill = ill; e.flt = flt;
    return e;
  endfunction

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Drives one instruction from a FETCH state and records what the control emits until retire or trap.
  task automatic run_instr(input logic [31:0] ins, input int fetch_wait, input int mem_wait,
                           input logic bt, output obs_t o);
    int mem_seen = 0;
    o = '0;
    for (int c = 1; c <= 40; c++) begin
      imem_rvalid  = (c > fetch_wait);
      imem_rdata   = (c == fetch_wait + 1) ? ins : 32'hFFFF_FFFF;
      dmem_ready   = (mem_wait >= 0) && (mem_seen >= mem_wait);
      branch_taken = bt;
      @(negedge clk);
      if (imem_req) o.imem_n = o.imem_n + 8'd1;
      if (c == fetch_wait + 3) begin o.alu = alu_control_en; o.imm = alu_src_imm; end
      if (dmem_req) mem_seen++;
      o.we = o.we | dmem_we;
      if (register_write_en) o.wr_n = o.wr_n + 8'd1;
      o.ir = instr; o.ill = illegal_instr; o.flt = mem_fault;
      if (pc_write_en) begin o.retire_c = 8'(c); o.pc_src = pc_src; o.wb_sel = wb_sel; end
      @(posedge clk); #1;
      if (o.retire_c != 0 || o.ill || o.flt) break;
    end
    o.mem_n = 8'(mem_seen);
    imem_rvalid = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; imem_rvalid = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ret_since_reset = 0;
  endtask

  task automatic test_reset();
    logic [47:0] vec;
    imem_rvalid = 1'b1; imem_rdata = I_ADD; dmem_ready = 1'b1; branch_taken = 1'b1;
    @(negedge clk);
    vec = {imem_req, dmem_req, dmem_we, register_write_en, alu_control_en, alu_src_imm,
           wb_sel, pc_write_en, pc_src, illegal_instr, mem_fault, instr};
    checks++;
    if (vec !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", vec); end
`ifdef PERF_CNT_EN
    checks++;
    if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
`endif
    imem_rvalid = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b want 0", imem_req); end
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_after_idle: got %b want 1", imem_req); end
  endtask

  task automatic test_r_alu();
    logic [3:0]  codes [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
    logic [31:0] ins [10];
    logic [3:0]  alu [10];
    obs_t o, e;
    for (int i = 0; i < 8; i++) begin ins[i] = mk_r(7'h00, 3'(i)); alu[i] = codes[i]; end
    ins[8] = mk_r(7'h20, 3'd0); alu[8] = 4'b1000;
    ins[9] = mk_r(7'h20, 3'd5); alu[9] = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(mk_exp(4, 2'b00, 1, 2'b00, alu[i], 1'b0, 0, 1'b0, 1, ins[i], 1'b0, 1'b0));
      ret_since_reset++;
      run_instr(ins[i], 0, 0, 1'b0, o);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL r_alu %h: got %p want %p", ins[i], o, e); end
    end
  endtask

  task automatic test_i_alu();
    logic [31:0] ins [4] = '{32'h40335293, 32'h00335293, 32'hC0008093, 32'h4000F093};
    logic [3:0]  alu [4] = '{4'b1101, 4'b0101, 4'b0000, 4'b0111};
    obs_t o, e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk_exp(4, 2'b00, 1, 2'b00, alu[i], 1'b1, 0, 1'b0, 1, ins[i], 1'b0, 1'b0));
      ret_since_reset++;
      run_instr(ins[i], 0, 0, 1'b0, o);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL i_alu %h: got %p want %p", ins[i], o, e); end
    end
  endtask

  task automatic test_wb_classes();
    logic [31:0] ins [5] = '{32'h008000EF, 32'h000100E7, 32'h123452B7, 32'h00001297, 32'h00208033};
    logic [1:0]  ps  [5] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0]  wb  [5] = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b00};
    int          wr  [5] = '{1, 1, 1, 1, 0};
    logic        imm [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    obs_t o, e;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk_exp(4, ps[i], wr[i], wb[i], 4'b0000, imm[i], 0, 1'b0, 1, ins[i], 1'b0, 1'b0));
      ret_since_reset++;
      run_instr(ins[i], 0, 0, 1'b0, o);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL wb_class %h: got %p want %p", ins[i], o, e); end
    end
  endtask

  task automatic test_fetch_wait();
    obs_t o, e;
    exp_q.push_back(mk_exp(6, 2'b00, 1, 2'b00, 4'b0000, 1'b0, 0, 1'b0, 3, I_ADD, 1'b0, 1'b0));
    ret_since_reset++;
    run_instr(I_ADD, 2, 0, 1'b0, o);
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin errors++; $display("FAIL fetch_wait: got %p want %p", o, e); end
  endtask

  task automatic test_load_store();
    logic [31:0] ins [3] = '{I_LW, I_LW, I_SW};
    int          mw  [3] = '{0, 2, 0};
    obs_t o, e;
    exp_q.push_back(mk_exp(5, 2'b00, 1, 2'b01, 4'b0000, 1'b1, 1, 1'b0, 1, I_LW, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(7, 2'b00, 1, 2'b01, 4'b0000, 1'b1, 3, 1'b0, 1, I_LW, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(4, 2'b00, 0, 2'b00, 4'b0000, 1'b1, 1, 1'b1, 1, I_SW, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      ret_since_reset++;
      run_instr(ins[i], 0, mw[i], 1'b0, o);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL load_store %0d: got %p want %p", i, o, e); end
    end
  endtask

  task automatic test_branch();
    obs_t o, e;
    for (int t = 1; t >= 0; t--) begin
      exp_q.push_back(mk_exp(3, (t == 1) ? 2'b01 : 2'b00, 0, 2'b00, 4'b1000, 1'b0, 0, 1'b0, 1,
                             I_BEQ, 1'b0, 1'b0));
      ret_since_reset++;
      run_instr(I_BEQ, 0, 0, 1'(t), o);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL branch taken=%0d: got %p want %p", t, o, e); end
    end
  endtask

  task automatic test_mem_fault();
    obs_t o, e;
    exp_q.push_back(mk_exp(0, 2'b00, 0, 2'b00, 4'b0000, 1'b1, 16, 1'b1, 1, I_SW, 1'b0, 1'b1));
    run_instr(I_SW, 0, -1, 1'b0, o);
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin errors++; $display("FAIL mem_fault: got %p want %p", o, e); end
`ifdef PERF_CNT_EN
    checks++;
    if (instret !== 32'(ret_since_reset)) begin
      errors++; $display("FAIL instret: got %0d want %0d", instret, ret_since_reset);
    end
`endif
    do_reset();
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2];
    obs_t o, e;
    int   req_n;
    ins[0] = 32'h0000007F;
    ins[1] = mk_r(7'h20, 3'd1);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk_exp(0, 2'b00, 0, 2'b00, 4'b0000, 1'b0, 0, 1'b0, 1, ins[i], 1'b1, 1'b0));
      run_instr(ins[i], 0, 0, 1'b0, o);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL illegal %h: got %p want %p", ins[i], o, e); end
      req_n = 0;
      for (int c = 0; c < 5; c++) begin
        imem_rvalid = 1'b1; imem_rdata = I_ADD; dmem_ready = 1'b1;
        @(negedge clk);
        if (imem_req || pc_write_en || register_write_en) req_n++;
        @(posedge clk); #1;
      end
      checks++;
      if (req_n !== 0 || illegal_instr !== 1'b1) begin
        errors++; $display("FAIL trap_absorb: got strobes=%0d ill=%b want 0 1", req_n, illegal_instr);
      end
      do_reset();
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [35:0] vec;
    dmem_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      imem_rvalid = (c == 1); imem_rdata = I_LW;
      @(negedge clk);
      if (c < 5) begin @(posedge clk); #1; end
    end
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_req: got %b want 1", dmem_req); end
    #2 rst_n = 1'b0;
    #1;
    vec = {dmem_req, pc_write_en, register_write_en, imem_req, instr};
    checks++;
    if (vec !== '0) begin errors++; $display("FAIL mid_mem_abort: got %h want 0", vec); end
`ifdef PERF_CNT_EN
    checks++;
    if (instret !== 32'd0) begin errors++; $display("FAIL abort_instret: got %0d want 0", instret); end
`endif
    imem_rvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL release_idle: got %b want 0", imem_req); end
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL release_fetch: got %b want 1", imem_req); end
    ret_since_reset = 0;
  endtask

  initial begin
    imem_rvalid = 1'b0; imem_rdata = '0; dmem_ready = 1'b0; branch_taken = 1'b0;
    test_reset();
    test_r_alu();
    test_i_alu();
    test_wb_classes();
    test_fetch_wait();
    test_load_store();
    test_branch();
    test_mem_fault();
    test_illegal();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
